// File: rtl/tristate_bus_arbiter.sv
// Round-robin owner selection for four tristate drivers sharing one bus.
// Ports: clk, rst, req[3:0] in; en[3:0], owner[1:0], busy, turn out.
module tristate_bus_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int TURN     = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] en,
  output logic [1:0] owner,
  output logic       busy,
  output logic       turn
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_TURN
  } state_t;

  localparam logic [7:0] HLAST = 8'(MAX_HOLD - 1);
  localparam logic [3:0] TLAST = 4'(TURN - 1);

  state_t     state, n_state;
  logic [1:0] ptr, n_ptr;
  logic [7:0] hcnt, n_hcnt;
  logic [3:0] tcnt, n_tcnt;
  logic [3:0] n_en;
  logic [1:0] n_owner;
  logic       n_busy, n_turn;

  logic [1:0] win;
  logic       found;
  logic [1:0] idx;
  logic       others;
  logic       hlast;
  logic       do_grant;

  // First set bit at or after ptr, wrapping modulo 4.
  always_comb begin
    win   = 2'd0;
    found = 1'b0;
    idx   = 2'd0;
    for (int i = 0; i < 4; i++) begin
      idx = ptr + 2'(i);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  // en equals onehot(owner) while granted, so this is "anyone else".
  assign others = |(req & ~en);
  assign hlast  = (hcnt == HLAST);

  always_comb begin
    n_state  = state;
    n_en     = en;
    n_owner  = owner;
    n_busy   = busy;
    n_turn   = turn;
    n_ptr    = ptr;
    n_hcnt   = hcnt;
    n_tcnt   = tcnt;
    do_grant = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (|req) do_grant = 1'b1;
      end
      S_GRANT: begin
        if (!req[owner] || (hlast && others)) begin
          n_state = S_TURN;
          n_en    = 4'b0000;
          n_busy  = 1'b0;
          n_turn  = 1'b1;
          n_tcnt  = 4'd0;
        end else if (hlast) begin
          // Nobody waiting: keep the bus, open a new window.
          n_hcnt = 8'd0;
        end else begin
          n_hcnt = hcnt + 8'd1;
        end
      end
      S_TURN: begin
        if (tcnt == TLAST) begin
          n_turn = 1'b0;
          if (|req) do_grant = 1'b1;
          else      n_state  = S_IDLE;
        end else begin
          n_tcnt = tcnt + 4'd1;
        end
      end
      default: n_state = S_IDLE;
    endcase
    if (do_grant) begin
      n_state = S_GRANT;
      n_en    = 4'b0001 << win;
      n_owner = win;
      n_busy  = 1'b1;
      n_hcnt  = 8'd0;
      n_ptr   = win + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      en    <= 4'b0000;
      owner <= 2'd0;
      busy  <= 1'b0;
      turn  <= 1'b0;
      ptr   <= 2'd0;
      hcnt  <= 8'd0;
      tcnt  <= 4'd0;
    end else begin
      state <= n_state;
      en    <= n_en;
      owner <= n_owner;
      busy  <= n_busy;
      turn  <= n_turn;
      ptr   <= n_ptr;
      hcnt  <= n_hcnt;
      tcnt  <= n_tcnt;
    end
  end

endmodule
